// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// requester indices and default bus widths.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_AUX = 1'b1;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus the memory.
interface mem_arb_if #(
   parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              mem_clk;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [DATA_W-1:0] mem_out;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      output gnt0, gnt1, done0, done1, rdata0, rdata1,
             mem_clk, mem_we, mem_addr, mem_data
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
      input  gnt0, gnt1, done0, done1, rdata0, rdata1,
             mem_clk, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select. MEM_ARB_RR_EN selects round-robin tie-break
// on `last`; otherwise requester 0 always wins a tie.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic win
);

`ifdef MEM_ARB_RR_EN
   always_comb begin
      valid = req0 | req1;
      win   = REQ_CPU;
      if (req0 && req1) begin
         // Tie goes to whoever was not served last.
         win = ~last;
      end else if (req1) begin
         win = REQ_AUX;
      end
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      valid = req0 | req1;
      win   = (req1 && !req0) ? REQ_AUX : REQ_CPU;
   end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter and three-phase access sequencer for the shared data memory.
// Define MEM_ARB_RR_EN for round-robin tie-break; default is fixed priority.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input logic       clk,
   input logic       reset,
   mem_arb_if.slave  bus
);

   state_t            state, state_n;
   logic              valid, win, last;
   logic              cur, cur_n;
   logic              we_l, we_n;
   logic              gnt0_n, gnt1_n, done0_n, done1_n;
   logic              mem_clk_n, mem_we_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] data_n;
   logic [DATA_W-1:0] rdata0_n, rdata1_n;

   mem_arb_pick u_pick (
      .req0  (bus.req0),
      .req1  (bus.req1),
      .last  (last),
      .valid (valid),
      .win   (win)
   );

`ifdef MEM_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= REQ_AUX;
      end else if (state == IDLE && valid) begin
         last <= win;
      end
   end
`else
   assign last = REQ_AUX;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Outputs are computed one state ahead so that every port is registered;
   // the address/data latch doubles as mem_addr/mem_data, loaded at grant.
   always_comb begin
      state_n   = state;
      cur_n     = cur;
      we_n      = we_l;
      gnt0_n    = 1'b0;
      gnt1_n    = 1'b0;
      done0_n   = 1'b0;
      done1_n   = 1'b0;
      mem_clk_n = 1'b0;
      mem_we_n  = 1'b0;
      addr_n    = bus.mem_addr;
      data_n    = bus.mem_data;
      rdata0_n  = bus.rdata0;
      rdata1_n  = bus.rdata1;
      case (state)
         IDLE: begin
            if (valid) begin
               state_n = ISSUE;
               cur_n   = win;
               if (win == REQ_AUX) begin
                  gnt1_n = 1'b1;
                  we_n   = bus.we1;
                  addr_n = bus.addr1;
                  data_n = bus.wdata1;
               end else begin
                  gnt0_n = 1'b1;
                  we_n   = bus.we0;
                  addr_n = bus.addr0;
                  data_n = bus.wdata0;
               end
            end
         end
         ISSUE: begin
            state_n   = CAPTURE;
            mem_clk_n = 1'b1;
            mem_we_n  = we_l;
         end
         CAPTURE: begin
            state_n = IDLE;
            if (cur == REQ_AUX) begin
               done1_n = 1'b1;
               if (!we_l) rdata1_n = bus.mem_out;
            end else begin
               done0_n = 1'b1;
               if (!we_l) rdata0_n = bus.mem_out;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur          <= REQ_CPU;
         we_l         <= 1'b0;
         bus.gnt0     <= 1'b0;
         bus.gnt1     <= 1'b0;
         bus.done0    <= 1'b0;
         bus.done1    <= 1'b0;
         bus.mem_clk  <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
         bus.rdata0   <= '0;
         bus.rdata1   <= '0;
      end else begin
         cur          <= cur_n;
         we_l         <= we_n;
         bus.gnt0     <= gnt0_n;
         bus.gnt1     <= gnt1_n;
         bus.done0    <= done0_n;
         bus.done1    <= done1_n;
         bus.mem_clk  <= mem_clk_n;
         bus.mem_we   <= mem_we_n;
         bus.mem_addr <= addr_n;
         bus.mem_data <= data_n;
         bus.rdata0   <= rdata0_n;
         bus.rdata1   <= rdata1_n;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 16x4 memory and per-port
// scoreboards of expected completions.
module tb_mem_arb;
   import mem_arb_pkg::*;

   typedef struct packed {
      logic       rd;
      logic [3:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc_n = 0;
   int   g_cyc [2];
   int   gnt_log [$];
   exp_t exp0 [$];
   exp_t exp1 [$];
   logic [3:0] ref_mem [16];
   logic [3:0] mem [16] = '{4'h5, 4'h4, 4'h7, 4'h6, 4'h1, 4'h0, 4'h3, 4'h2,
                            4'hD, 4'hC, 4'hF, 4'hE, 4'h9, 4'h8, 4'hB, 4'hA};
   bit   hold = 1'b0;

   always #5 clk = ~clk;

   mem_arb_if #(.ADDR_W(4), .DATA_W(4)) bus ();

   mem_arb #(.ADDR_W(4), .DATA_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge bus.mem_clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
   end
   assign bus.mem_out = mem[bus.mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock, sampled 1 time unit after the edge, with per-cycle monitoring.
   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      cyc_n++;
      check("gnt_overlap", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
      check("done_overlap", {31'd0, bus.done0 & bus.done1}, 32'd0);
      if (bus.gnt0) begin
         g_cyc[0] = cyc_n;
         gnt_log.push_back(0);
         if (!hold) bus.req0 = 1'b0;
      end
      if (bus.gnt1) begin
         g_cyc[1] = cyc_n;
         gnt_log.push_back(1);
         if (!hold) bus.req1 = 1'b0;
      end
      if (bus.done0) begin
         check("done0_gnt_gap", cyc_n - g_cyc[0], 32'd2);
         check("done0_expected", {31'd0, exp0.size() > 0}, 32'd1);
         if (exp0.size() > 0) begin
            e = exp0.pop_front();
            if (e.rd) check("rdata0", {28'd0, bus.rdata0}, {28'd0, e.data});
         end
      end
      if (bus.done1) begin
         check("done1_gnt_gap", cyc_n - g_cyc[1], 32'd2);
         check("done1_expected", {31'd0, exp1.size() > 0}, 32'd1);
         if (exp1.size() > 0) begin
            e = exp1.pop_front();
            if (e.rd) check("rdata1", {28'd0, bus.rdata1}, {28'd0, e.data});
         end
      end
   endtask

   task automatic push_exp(input int p, input bit w, input logic [3:0] a, input logic [3:0] d);
      exp_t e;
      e.rd   = !w;
      e.data = ref_mem[a];
      if (p == 0) exp0.push_back(e);
      else        exp1.push_back(e);
      if (w) ref_mem[a] = d;
   endtask

   task automatic drive(input int p, input bit w, input logic [3:0] a, input logic [3:0] d);
      if (p == 0) begin
         bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask

   // Single isolated access with latency checks on gnt and done.
   task automatic access(input int p, input bit w, input logic [3:0] a, input logic [3:0] d);
      int t0;
      bit seen;
      push_exp(p, w, a, d);
      drive(p, w, a, d);
      t0 = cyc_n;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cyc();
         if ((p == 0) ? bus.done0 : bus.done1) seen = 1'b1;
      end
      check("access_done_seen", {31'd0, seen}, 32'd1);
      check("access_done_lat", cyc_n - t0, 32'd3);
      check("access_gnt_lat", g_cyc[p] - t0, 32'd1);
   endtask

   initial begin
      int base;
      int d;
      int n1;
      bit seen;
      int exp_seq [4];

      for (int i = 0; i < 16; i++) ref_mem[i] = 4'(i) ^ 4'h5;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      g_cyc[0] = 0;
      g_cyc[1] = 0;

      // Reset, then idle: every output stays at zero.
      repeat (3) cyc();
      check("reset_outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_clk,
                              bus.mem_we, bus.mem_addr, bus.mem_data, bus.rdata0, bus.rdata1}, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("idle_outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_clk,
                                bus.mem_we, bus.mem_addr, bus.mem_data, bus.rdata0, bus.rdata1}, 32'd0);
      end

      // Both requesters read address 3 continuously.
`ifdef MEM_ARB_RR_EN
      exp_seq = '{0, 1, 0, 1};
`else
      exp_seq = '{0, 0, 0, 0};
`endif
      for (int i = 0; i < 4; i++) push_exp(exp_seq[i], 1'b0, 4'h3, 4'h0);
      hold = 1'b1;
      base = gnt_log.size();
      drive(0, 1'b0, 4'h3, 4'h0);
      drive(1, 1'b0, 4'h3, 4'h0);
      for (int i = 0; i < 30 && gnt_log.size() < base + 4; i++) cyc();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      hold = 1'b0;
      check("tie_grant_count", gnt_log.size() - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (gnt_log.size() > base + i)
            check("tie_grant_order", gnt_log[base + i], exp_seq[i]);
      end
      for (int i = 0; i < 10 && (exp0.size() > 0 || exp1.size() > 0); i++) cyc();
      check("tie_drained", exp0.size() + exp1.size(), 32'd0);

      // Write then read back on port 0; the write must not touch rdata0.
      access(0, 1'b1, 4'h3, 4'hA);
      check("write_keeps_rdata0", {28'd0, bus.rdata0}, {28'd0, 4'h6});
      cyc();
      access(0, 1'b0, 4'h3, 4'h0);
      check("readback_a", {28'd0, bus.rdata0}, {28'd0, 4'hA});

      // Port 1 write to 7 aborted by reset in the ISSUE cycle.
      drive(1, 1'b1, 4'h7, 4'hC);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         cyc();
         if (bus.gnt1) seen = 1'b1;
      end
      check("abort_gnt1", {31'd0, seen}, 32'd1);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("abort_no_strobe", {30'd0, bus.mem_clk, bus.mem_we}, 32'd0);
         check("abort_no_done1", {31'd0, bus.done1}, 32'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("abort_quiet", {29'd0, bus.done1, bus.mem_clk, bus.mem_we}, 32'd0);
      end
      access(1, 1'b0, 4'h7, 4'h0);
      check("abort_mem_kept", {28'd0, bus.rdata1}, {28'd0, 4'h2});

      // Port 0 arrives while port 1's read of 12 is in flight.
      push_exp(1, 1'b0, 4'hC, 4'h0);
      drive(1, 1'b0, 4'hC, 4'h0);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         cyc();
         if (bus.gnt1) seen = 1'b1;
      end
      check("mid_gnt1", {31'd0, seen}, 32'd1);
      n1 = gnt_log.size();
      push_exp(0, 1'b0, 4'h3, 4'h0);
      drive(0, 1'b0, 4'h3, 4'h0);
      seen = 1'b0;
      for (int i = 0; i < 5 && !seen; i++) begin
         cyc();
         if (bus.done1) seen = 1'b1;
      end
      check("mid_done1", {31'd0, seen}, 32'd1);
      check("mid_no_early_gnt", gnt_log.size() - n1, 32'd0);
      d = cyc_n;
      cyc();
      check("mid_gnt0_after_done1", {31'd0, bus.gnt0}, 32'd1);
      check("mid_gnt0_cycle", cyc_n - d, 32'd1);
      for (int i = 0; i < 6 && exp0.size() > 0; i++) cyc();
      check("mid_drained", exp0.size() + exp1.size(), 32'd0);
      check("mid_rdata1_kept", {28'd0, bus.rdata1}, {28'd0, 4'h9});
      check("mid_rdata0", {28'd0, bus.rdata0}, {28'd0, 4'hA});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
